bist_controller: RTL and testbench
==================================

BIST_CONTROLLER -- requirements
Module: bist_controller

Interface
REQ-001 SHALL have parameter PAT_W, default 3: CUT input width, LFSR width, minimum 2.
REQ-002 SHALL have parameter PAT_POLY, default 3'b110: LFSR tap mask; feedback = XOR-reduce(lfsr & PAT_POLY).
REQ-003 SHALL have parameter PAT_SEED, default 3'b001: LFSR start value, nonzero.
REQ-004 SHALL have parameter RSP_W, default 2: CUT output width, at most SIG_W.
REQ-005 SHALL have parameter SIG_W, default 8: MISR width.
REQ-006 SHALL have parameter SIG_POLY, default 8'h1D: MISR feedback mask.
REQ-007 SHALL have port clk, input, 1: single clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1: begin a test run; sampled only in IDLE.
REQ-010 SHALL have port abort, input, 1: synchronous cancel of a run in progress.
REQ-011 SHALL have port golden_sig, input, SIG_W: expected signature, sampled in CMP.
REQ-012 SHALL have port resp_i, input, RSP_W: combinational CUT response to pat_o.
REQ-013 SHALL have port pat_o, output, PAT_W: registered pattern driven to the CUT.
REQ-014 SHALL have port busy, output, 1: high in RUN and CMP.
REQ-015 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-016 SHALL have port pass, output, 1: result of the last completed run.
REQ-017 SHALL have port sig_o, output, SIG_W: current MISR contents.

Function
REQ-018 FSM SHALL have states IDLE, RUN, CMP; done is a registered pulse, not a state.
REQ-019 IDLE with start=1 SHALL set lfsr<=PAT_SEED, sig<=0, cnt<=0, pass<=0 and move to RUN; pat_o SHALL be 0 in IDLE.
REQ-020 In RUN, pat_o SHALL equal lfsr; each edge SHALL set lfsr<={lfsr[PAT_W-2:0],fb}, cnt<=cnt+1, and absorb resp_i into the MISR.
REQ-021 MISR update SHALL be sig<={sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : 0) ^ zero-extended resp_i.
REQ-022 RUN SHALL apply NUM_PAT patterns (REQ-033), then move to CMP on the edge that absorbs the last response.
REQ-023 CMP SHALL last one cycle; on exit it SHALL register pass<=(sig==golden_sig) and done<=1, and move to IDLE.
REQ-024 done SHALL be high for exactly one cycle; pass SHALL hold until the next accepted start.
REQ-025 start SHALL be ignored while busy; start and done coinciding SHALL NOT begin a new run in that cycle.
REQ-026 abort=1 in RUN or CMP SHALL return to IDLE on the next edge with pass=0, done=0, pat_o=0; sig_o SHALL retain its value; abort SHALL take priority over start and over CMP completion.
REQ-027 sig_o SHALL equal the MISR register directly, with no extra latency.
REQ-028 Latency SHALL be: start at edge E0 -> done high after edge E0+NUM_PAT+1; busy high from E0 to E0+NUM_PAT+1.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, lfsr=PAT_SEED, sig=0, cnt=0, pat_o=0, busy=0, done=0, pass=0.
REQ-030 Reset during RUN SHALL discard the run; no done pulse SHALL follow reset release.
REQ-031 Deassertion SHALL take effect on the first clk edge with rst_n=1.

Configuration
REQ-032 Macro BIST_ALLZERO_EN SHALL control the all-zero pattern.
REQ-033 With BIST_ALLZERO_EN defined, after the 2^PAT_W-1 LFSR states, RUN SHALL apply one extra all-zero pattern, so NUM_PAT=2^PAT_W; otherwise NUM_PAT=2^PAT_W-1 and all-zero SHALL never appear on pat_o.

Verification
REQ-034 Defaults, macro off, start pulse -> pat_o 001,010,101,011,111,110,100 on consecutive cycles; done after edge E0+8.
REQ-035 Macro on, same stimulus -> the same 7 patterns then 000; done after edge E0+9.
REQ-036 Full-adder CUT, golden_sig = signature from a known-good run -> pass=1; repeat with cout stuck-at-0 -> pass=0, sig_o differs.
REQ-037 abort on 3rd RUN cycle -> IDLE next edge, pat_o=0, no done pulse, pass=0; restart -> full 7-pattern sequence from 001.
REQ-038 start held high continuously -> back-to-back runs with one IDLE cycle between done and the next RUN; start during busy has no effect.
REQ-039 rst_n low mid-RUN -> all outputs 0 asynchronously (before the next clk edge); no done pulse after release.

Source files
------------

// File: rtl/bist_controller.sv
// -----------------------------------------------------------------------------
// bist_controller
//
// Logic BIST sequencer. An LFSR drives test patterns into a combinational
// circuit-under-test. A MISR folds the responses into a signature. At the end
// of the run, the signature is compared against a golden value.
//
// Configuration macro:
//   BIST_ALLZERO_EN - when defined, one extra all-zero pattern is applied
//                     after the 2^PAT_W-1 LFSR states, so the run is
//                     2^PAT_W patterns long. When undefined, the run is
//                     2^PAT_W-1 patterns long and pat_o is never zero in RUN.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - begin a run; only sampled in IDLE
//   abort      - synchronous cancel of a run in RUN or CMP
//   golden_sig - expected signature, sampled in the CMP cycle
//   resp_i     - combinational CUT response to pat_o
//   pat_o      - pattern driven to the CUT (zero outside RUN)
//   busy       - high in RUN and CMP
//   done       - one-cycle completion pulse
//   pass       - result of the last completed run
//   sig_o      - current MISR contents
// -----------------------------------------------------------------------------
module bist_controller #(
    parameter int                PAT_W    = 3,
    parameter logic [PAT_W-1:0]  PAT_POLY = 3'b110,
    parameter logic [PAT_W-1:0]  PAT_SEED = 3'b001,
    parameter int                RSP_W    = 2,
    parameter int                SIG_W    = 8,
    parameter logic [SIG_W-1:0]  SIG_POLY = 8'h1D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] golden_sig,
    input  logic [RSP_W-1:0] resp_i,
    output logic [PAT_W-1:0] pat_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] sig_o
);

    // One spare bit so the counter can index 2^PAT_W patterns.
    localparam int CNT_W = PAT_W + 1;

`ifdef BIST_ALLZERO_EN
    localparam int  NUM_PAT = (1 << PAT_W);
    localparam logic ZERO_PAT_EN = 1'b1;
`else
    localparam int  NUM_PAT = (1 << PAT_W) - 1;
    localparam logic ZERO_PAT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PAT - 1);
    // Index of the appended all-zero pattern, one past the last LFSR state.
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'((1 << PAT_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_CMP  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [PAT_W-1:0] lfsr;
    logic [SIG_W-1:0] sig;
    logic [CNT_W-1:0] cnt;

    function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] cur);
        logic fb;
        fb = ^(cur & PAT_POLY);
        return {cur[PAT_W-2:0], fb};
    endfunction

    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] cur,
                                                   input logic [RSP_W-1:0] rsp);
        logic [SIG_W-1:0] fold;
        fold = cur[SIG_W-1] ? SIG_POLY : '0;
        return {cur[SIG_W-2:0], 1'b0} ^ fold ^ SIG_W'(rsp);
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Abort wins over both start and CMP completion.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (abort)                state_nxt = S_IDLE;
                else if (cnt == CNT_LAST) state_nxt = S_CMP;
            end
            S_CMP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs. pat_o is decoded only from registers, so the CUT sees a
    // pattern that changes on clock edges only.
    always_comb begin
        busy  = 1'b0;
        pat_o = '0;
        case (state)
            S_RUN: begin
                busy = 1'b1;
                if (!(ZERO_PAT_EN && cnt == CNT_ZERO)) pat_o = lfsr;
            end
            S_CMP:   busy = 1'b1;
            default: ;
        endcase
    end

    // Pattern generator, signature register, counter and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= PAT_SEED;
            sig  <= '0;
            cnt  <= '0;
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lfsr <= PAT_SEED;
                        sig  <= '0;
                        cnt  <= '0;
                        pass <= 1'b0;
                    end
                end
                S_RUN: begin
                    // On abort the signature is left as it stood.
                    if (!abort) begin
                        lfsr <= lfsr_next(lfsr);
                        cnt  <= cnt + CNT_W'(1);
                        sig  <= misr_next(sig, resp_i);
                    end
                end
                S_CMP: begin
                    if (abort) begin
                        pass <= 1'b0;
                    end else begin
                        pass <= (sig == golden_sig);
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sig_o = sig;

endmodule

// File: tb/tb_bist_controller.sv
// -----------------------------------------------------------------------------
// tb_bist_controller
//
// Directed bench for bist_controller with default parameters. A full-adder
// CUT (pat_o = {a,b,cin}, resp_i = {cout,sum}) is modelled here. There is a
// switch that holds cout stuck at zero. Signatures are hand-computed for
// both the macro-off and the macro-on (BIST_ALLZERO_EN) builds.
// -----------------------------------------------------------------------------
module tb_bist_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] golden_sig = 8'h00;
    logic [1:0] resp_i;
    logic [2:0] pat_o;
    logic       busy, done, pass;
    logic [7:0] sig_o;
    logic       stuck_cout = 1'b0;

    int errors = 0;
    int checks = 0;

`ifdef BIST_ALLZERO_EN
    localparam int         NUM      = 8;
    localparam logic [7:0] SIG_GOOD = 8'hB2;
    localparam logic [7:0] SIG_BAD  = 8'hCA;
`else
    localparam int         NUM      = 7;
    localparam logic [7:0] SIG_GOOD = 8'h59;
    localparam logic [7:0] SIG_BAD  = 8'h65;
`endif

    logic [2:0] exp_pat [8] = '{3'b001, 3'b010, 3'b101, 3'b011,
                                3'b111, 3'b110, 3'b100, 3'b000};

    bist_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .golden_sig (golden_sig),
        .resp_i     (resp_i),
        .pat_o      (pat_o),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .sig_o      (sig_o)
    );

    always #5 clk = ~clk;

    // Full-adder CUT.
    always_comb begin
        logic s, co;
        s  = pat_o[2] ^ pat_o[1] ^ pat_o[0];
        co = (pat_o[2] & pat_o[1]) | (pat_o[2] & pat_o[0]) | (pat_o[1] & pat_o[0]);
        resp_i = {co & ~stuck_cout, s};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a run from IDLE and checks every pattern. Returns at the negedge
    // inside the CMP cycle.
    task automatic run_to_cmp(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            chk({tag, "_pat"}, 32'(pat_o), 32'(exp_pat[i]));
            if (i == 0) chk({tag, "_busy_run"}, 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk({tag, "_busy_cmp"}, 32'(busy), 32'd1);
        chk({tag, "_nodone_cmp"}, 32'(done), 32'd0);
    endtask

    task automatic run_full(input string tag, input logic exp_pass, input logic [7:0] exp_sig);
        run_to_cmp(tag);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'(exp_pass));
        chk({tag, "_sig"}, 32'(sig_o), 32'(exp_sig));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_pass_hold"}, 32'(pass), 32'(exp_pass));
    endtask

    initial begin
        int done_seen;

        // Reset state.
        #12;
        chk("rst_pat", 32'(pat_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_sig", 32'(sig_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Known-good CUT, then the cout stuck-at-0 fault, then good again.
        golden_sig = SIG_GOOD;
        run_full("good", 1'b1, SIG_GOOD);
        stuck_cout = 1'b1;
        run_full("stuck", 1'b0, SIG_BAD);
        stuck_cout = 1'b0;
        run_full("good2", 1'b1, SIG_GOOD);

        // Abort on the third RUN cycle. Two responses have been absorbed
        // (01, 01), so the signature is 0x03.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ab_pat0", 32'(pat_o), 32'h1);
        @(negedge clk);
        chk("ab_pat1", 32'(pat_o), 32'h2);
        @(negedge clk);
        chk("ab_pat2", 32'(pat_o), 32'h5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_pat", 32'(pat_o), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_pass", 32'(pass), 32'd0);
        chk("ab_sig", 32'(sig_o), 32'h03);
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("ab_no_done", 32'(done_seen), 32'd0);
        run_full("restart", 1'b1, SIG_GOOD);

        // Abort in CMP beats completion.
        run_to_cmp("abcmp");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abcmp_done", 32'(done), 32'd0);
        chk("abcmp_pass", 32'(pass), 32'd0);
        chk("abcmp_busy", 32'(busy), 32'd0);

        // Start held high: back-to-back runs with exactly one IDLE (done) cycle.
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NUM; i++) begin
            chk("hold_pat", 32'(pat_o), 32'(exp_pat[i]));
            @(negedge clk);
        end
        chk("hold_cmp", 32'(busy), 32'd1);
        @(negedge clk);
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("hold_rerun_busy", 32'(busy), 32'd1);
        chk("hold_rerun_pat", 32'(pat_o), 32'h1);
        start = 1'b0;
        for (int k = 0; k < 20 && !done; k++) @(negedge clk);
        chk("hold_done2", 32'(done), 32'd1);
        chk("hold_pass2", 32'(pass), 32'd1);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_pat", 32'(pat_o), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_pass", 32'(pass), 32'd0);
        chk("arst_sig", 32'(sig_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        chk("arst_no_done", 32'(done_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
